// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// default widths and the bubble/NOP instruction word.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StLoad  = 2'd2
  } ifetch_state_e;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ifetch_pc_gen.sv
// PC register and next-PC selection for the instruction fetch controller.
// Priority while fetching: redirect > stall > increment. The PC returns to
// the reset value at reset and when a load session ends.
module ifetch_pc_gen
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  ifetch_state_e       i_state,
  input  logic                i_run,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [ADDR_W-1:0]   i_redirect_addr,
  input  logic                i_load_req,
  output logic [ADDR_W-1:0]   o_pc
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // Next-PC mux; the increment wraps naturally at 2**ADDR_W.
  always_comb begin
    w_pc_next = r_pc;
    case (i_state)
      StLoad: begin
        if (!i_load_req) w_pc_next = ResetPc;
      end
      StFetch: begin
        if (i_run) begin
          if (i_redirect)    w_pc_next = i_redirect_addr;
          else if (!i_stall) w_pc_next = r_pc + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) r_pc <= ResetPc;
    else       r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: shares the single instruction-memory port
// between the CPU fetch path and the program loader, sequences the PC and
// registers the fetched instruction with one cycle of latency.
// Optional feature macro: IFETCH_PERF_EN adds saturating FetchCount and
// StallCount performance counters.
module instruction_fetch_controller
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Run,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  input  logic              LoadReq,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadGrant,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Instruction,
  output logic              InstrValid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
`endif
);

  ifetch_state_e     r_state;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] w_pc;

  ifetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk             (clk),
    .reset           (reset),
    .i_state         (r_state),
    .i_run           (Run),
    .i_stall         (Stall),
    .i_redirect      (Redirect),
    .i_redirect_addr (RedirectAddr),
    .i_load_req      (LoadReq),
    .o_pc            (w_pc)
  );

  // Port-ownership FSM plus registered instruction/valid.
  // Loader is only admitted from IDLE, so a fetch in flight is never interrupted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_instr <= DATA_W'(NOP);
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (LoadReq)  r_state <= StLoad;
          else if (Run) r_state <= StFetch;
        end
        StLoad: begin
          if (!LoadReq) r_state <= StIdle;
        end
        StFetch: begin
          if (!Run) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
          end else if (Redirect) begin
            // One bubble; the stale instruction word is kept but marked invalid.
            r_valid <= 1'b0;
          end else if (!Stall) begin
            r_instr <= MemRdData;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: loader drives the port only while granted.
  always_comb begin
    LoadGrant = (r_state == StLoad);
    MemAddr   = LoadGrant ? LoadAddr : w_pc;
    MemWrEn   = LoadGrant & LoadReq;
    MemWrData = LoadData;
  end

  assign PC          = w_pc;
  assign Instruction = r_instr;
  assign InstrValid  = r_valid;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_fetch_evt;
  logic        w_stall_evt;

  assign w_fetch_evt = (r_state == StFetch) & Run & !Redirect & !Stall;
  assign w_stall_evt = (r_state == StFetch) & Stall & !Redirect;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch_evt && r_fetch_cnt != 32'hFFFF_FFFF) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_evt && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign StallCount = r_stall_cnt;
`endif

endmodule
